axis_conv_out_buffer: RTL

- Sits directly downstream of the convolution engine and consumes its valid-only output beat: CONV_UNITS words, plus last and user.
- The engine has no ready input. This block absorbs its output in a FIFO and converts it to a full AXIS master with backpressure.
- Raises s_stall early enough for the top level to drop the engine's aclken before the FIFO overflows.
- Optionally applies ReLU per beat, selected by the user bit.

---
 rtl/axis_conv_out_buffer_pkg.sv | 18 +
 rtl/axis_conv_out_buffer_fifo_mem.sv | 27 ++
 rtl/axis_conv_out_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/axis_conv_out_buffer_pkg.sv
// Shared constants and beat type for the convolution output buffer.
// The optional ReLU stage is controlled by the CONV_OUT_RELU_EN macro in the top.
package axis_conv_out_buffer_pkg;

    localparam int CONV_UNITS    = 8;
    localparam int DATA_WIDTH    = 16;
    localparam int TUSER_WIDTH   = 4;
    localparam int INDEX_IS_RELU = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t [CONV_UNITS-1:0]  data;
        logic                    last;
        logic [TUSER_WIDTH-1:0]  user;
    } beat_t;

endpackage

// File: rtl/axis_conv_out_buffer_fifo_mem.sv
// Beat storage for the output buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module conv_out_fifo_mem
    import axis_conv_out_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  beat_t         wdata,
    input  logic [AW-1:0] raddr,
    output beat_t         rdata
);

    beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_conv_out_buffer.sv
// Valid-only conv engine output -> AXIS master FIFO with early stall and sticky overflow.
// Define CONV_OUT_RELU_EN to zero negative words of beats whose user ReLU bit is set.
module axis_conv_out_buffer
    import axis_conv_out_buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 6
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_valid,
    input  logic [DATA_WIDTH-1:0]  s_data [CONV_UNITS],
    input  logic                   s_last,
    input  logic [TUSER_WIDTH-1:0] s_user,
    output logic                   s_stall,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data [CONV_UNITS],
    output logic                   m_last,
    output logic [TUSER_WIDTH-1:0] m_user,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - STALL_MARGIN);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          stall_q, stall_d;
    logic          full, empty, wr_en, rd_en;
    beat_t         wbeat, rbeat;

    // Flags come from the registered count, so a read cannot make room for a same-cycle write.
    assign full  = (count_q == FULL_LVL);
    assign empty = (count_q == '0);
    assign wr_en = s_valid && !full;
    assign rd_en = m_valid && m_ready;

    always_comb begin
        wbeat      = '0;
        wbeat.last = s_last;
        wbeat.user = s_user;
        for (int i = 0; i < CONV_UNITS; i++) begin
            wbeat.data[i] = s_data[i];
`ifdef CONV_OUT_RELU_EN
            if (s_user[INDEX_IS_RELU] && s_data[i][DATA_WIDTH-1]) begin
                wbeat.data[i] = '0;
            end
`endif
        end
    end

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q || (s_valid && full);
        stall_d    = (count_d >= STALL_LVL);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stall_q    <= stall_d;
        end
    end

    conv_out_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wbeat),
        .raddr (rd_ptr_q),
        .rdata (rbeat)
    );

    // First-word-fall-through: head entry is presented as soon as it is stored.
    always_comb begin
        for (int i = 0; i < CONV_UNITS; i++) begin
            m_data[i] = rbeat.data[i];
        end
    end

    assign m_last   = rbeat.last;
    assign m_user   = rbeat.user;
    assign m_valid  = !empty;
    assign s_stall  = stall_q;
    assign overflow = overflow_q;

endmodule
